// File: rtl/btn_pulse_gen_pkg.sv
// Shared constants for the button pulse generator and the LED stage it feeds:
// state encoding, default count values and a small sizing helper.
package btn_pulse_gen_pkg;

  localparam int DEF_DEBOUNCE_CNT = 5;
  localparam int DEF_HOLD_CNT     = 20;
  localparam int DEF_REPEAT_CNT   = 8;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_DB_PRESS   = 3'd1;
  localparam logic [2:0] ST_HELD       = 3'd2;
  localparam logic [2:0] ST_REPEAT     = 3'd3;
  localparam logic [2:0] ST_DB_RELEASE = 3'd4;

  typedef enum logic [2:0] {
    IDLE       = ST_IDLE,
    DB_PRESS   = ST_DB_PRESS,
    HELD       = ST_HELD,
    REPEAT     = ST_REPEAT,
    DB_RELEASE = ST_DB_RELEASE
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_pulse_gen_sync_2ff.sv
// Two-flop synchronizer for the raw push-button line. Both stages preset to 1
// so a reset always looks like a released (active-low) button.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Debounced push-button pulse generator with optional auto-repeat. One shared
// counter times every state and is cleared on each state change; pulse and
// pressed are registered so the LED stage sees clean, glitch-free strobes.
module btn_pulse_gen
  import btn_pulse_gen_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter int HOLD_CNT     = DEF_HOLD_CNT,
  parameter int REPEAT_CNT   = DEF_REPEAT_CNT,
  parameter int REPEAT_EN    = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulse,
  output logic pressed
);

  localparam int CNT_MAX = max3(DEBOUNCE_CNT, HOLD_CNT, REPEAT_CNT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam bit               RPT_ON    = (REPEAT_EN != 0);

  logic             sync_q;
  logic             btn_s;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             from_repeat;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_n),
    .q     (sync_q)
  );

  assign btn_s = ~sync_q;

  // Press/hold/repeat/release sequencing with the shared counter and outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      pulse       <= 1'b0;
      pressed     <= 1'b0;
      from_repeat <= 1'b0;
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) begin
            state <= DB_PRESS;
          end
        end
        DB_PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            pulse   <= 1'b1;
            pressed <= 1'b1;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!btn_s) begin
            state       <= DB_RELEASE;
            cnt         <= '0;
            from_repeat <= 1'b0;
          end else if (RPT_ON && (cnt == HOLD_LAST)) begin
            state <= REPEAT;
            cnt   <= '0;
            pulse <= 1'b1;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        REPEAT: begin
          // a release landing on a repeat boundary suppresses that pulse
          if (!btn_s) begin
            state       <= DB_RELEASE;
            cnt         <= '0;
            from_repeat <= 1'b1;
          end else if (cnt == RPT_LAST) begin
            cnt   <= '0;
            pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DB_RELEASE: begin
          if (btn_s) begin
            state <= from_repeat ? REPEAT : HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            pressed <= 1'b0;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CNT, default 5: number of consecutive stable synchronized samples required to accept a press or release (range 2..65535).
REQ-002 Parameter HOLD_CNT, default 20: cycles a press must be held after acceptance before auto-repeat starts.
REQ-003 Parameter REPEAT_CNT, default 8: cycles between auto-repeat pulses.
REQ-004 Parameter REPEAT_EN, default 1: 1 enables auto-repeat; 0 gives exactly one pulse per press.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 btn_n  input  1  raw active-low push-button, asynchronous to clk, may bounce.
REQ-008 pulse  output  1  registered one-cycle strobe per accepted press or repeat; feeds the downstream LED counter stage.
REQ-009 pressed  output  1  registered debounced button level, 1 = held.

Function
REQ-010 btn_n SHALL pass through a 2-flop synchronizer; the internal sample btn_s SHALL be the inverted second-flop output (1 = pressed).
REQ-011 A single counter, sized to the maximum of the three count parameters, SHALL time all states and SHALL be cleared on every state transition.
REQ-012 States SHALL be IDLE, DB_PRESS, HELD, REPEAT, DB_RELEASE.
REQ-013 IDLE: btn_s=1 -> DB_PRESS; otherwise stay.
REQ-014 DB_PRESS: btn_s=0 -> IDLE with no pulse; DEBOUNCE_CNT consecutive btn_s=1 samples, first sample included -> HELD, with pulse=1 for one cycle and pressed=1.
REQ-015 A btn_n held low from rising edge E0 SHALL produce pulse high for exactly the cycle after edge E0+DEBOUNCE_CNT+2: 7 edges at the default parameters.
REQ-016 HELD: btn_s=0 -> DB_RELEASE; counter reaching HOLD_CNT with REPEAT_EN=1 -> REPEAT with a one-cycle pulse; with REPEAT_EN=0, stay in HELD indefinitely.
REQ-017 REPEAT: one-cycle pulse every REPEAT_CNT cycles, counter wraps to 0 after each pulse; btn_s=0 -> DB_RELEASE.
REQ-018 DB_RELEASE: btn_s=1 -> return to the originating state, HELD or REPEAT, with the counter cleared and no pulse; DEBOUNCE_CNT consecutive btn_s=0 samples -> IDLE with pressed=0.
REQ-019 pressed SHALL fall on the same edge that enters IDLE from DB_RELEASE.
REQ-020 pulse SHALL never be high on two consecutive cycles and SHALL never assert in IDLE, DB_PRESS or DB_RELEASE.
REQ-021 When a repeat boundary and btn_s=0 occur in the same cycle, the release SHALL win: no pulse, next state DB_RELEASE.
REQ-022 The counter SHALL saturate rather than wrap in DB_PRESS, DB_RELEASE and HELD.

Reset
REQ-023 rst_n low SHALL immediately force both synchronizer flops to 1 (released), state to IDLE, counter to 0, pulse=0 and pressed=0.
REQ-024 Reset asserted mid-press SHALL NOT emit a pulse; after rst_n rises, a still-held button SHALL be re-debounced from DB_PRESS.

Structure
REQ-025 The state encoding (3-bit localparams IDLE=0, DB_PRESS=1, HELD=2, REPEAT=3, DB_RELEASE=4) and the default count constants SHALL live in the shared defines include used by the LED stage.
REQ-026 The 2-flop synchronizer SHALL be a separate sub-module named sync_2ff with ports clk, rst_n, d, q and reset value 1.
REQ-027 The top-level module SHALL contain the FSM, the counter and the output registers only.

Verification
REQ-028 Clean press: with defaults, btn_n low at 20 ns held for 300 ns -> exactly one pulse, 7 edges after first sampling; pressed high until DEBOUNCE_CNT+2 edges after release.
REQ-029 Bounce: btn_n toggles every cycle for 8 cycles, then stays low -> no pulse during toggling; one pulse 7 edges after the final stable low.
REQ-030 Glitch rejection: btn_n low for 3 cycles -> no pulse, pressed stays 0.
REQ-031 Auto-repeat: hold for 60 cycles with defaults -> first pulse, second pulse 20 cycles later, then pulses every 8 cycles until release; REPEAT_EN=0 -> one pulse only.
REQ-032 Release bounce in REPEAT: btn_n high for 2 cycles, then low -> no IDLE entry, pressed stays 1, repeat counter restarts.
REQ-033 Reset mid-hold: rst_n low for 2 cycles during HELD -> pulse=0 and pressed=0 immediately; with the button still held, a new pulse 7 edges after rst_n rises.
